// File: rtl/mp64_dma_arb_pkg.sv
// Shared types and defaults for the mp64 DMA arbiter and its picker.
package mp64_dma_arb_pkg;

  localparam int unsigned ADDR_W            = 64;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned CNT_W             = 8;
  localparam int unsigned ARB_MAX_BURST_DEF = 16;
  localparam int unsigned ARB_TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  // One memory-bus command as latched from the winning requester.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
  } mem_cmd_t;

endpackage

// File: rtl/mp64_dma_arb_if.sv
// Requester-side and memory-side signals of the DMA arbiter.
interface mp64_dma_arb_if
  import mp64_dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]        req;
  logic [ADDR_W*N_REQ-1:0] addr;
  logic [DATA_W*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]        wen;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        err;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_wen;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_ack;
  logic                    busy;

  // Arbiter side.
  modport slave (
    input  req, addr, wdata, wen, mem_rdata, mem_ack,
    output rdata, ack, err, mem_req, mem_addr, mem_wdata, mem_wen, busy
  );

  // Requester / memory-model side.
  modport master (
    output req, addr, wdata, wen, mem_rdata, mem_ack,
    input  rdata, ack, err, mem_req, mem_addr, mem_wdata, mem_wen, busy
  );

endinterface

// File: rtl/mp64_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module mp64_rr_pick
  import mp64_dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_c_o,
  output logic [IDX_W-1:0] idx_c_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest requester after last_i wins.
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % int'(N_REQ));
      if (req_i[cand]) begin
        valid_c_o = 1'b1;
        idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mp64_dma_arb.sv
// Round-robin DMA arbiter with burst limit and watchdog onto one byte-wide memory port.
module mp64_dma_arb
  import mp64_dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = ARB_MAX_BURST_DEF,
  parameter int unsigned TIMEOUT   = ARB_TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mp64_dma_arb_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, g_q, g_d;
  logic [CNT_W-1:0]  burst_q, burst_d, wdog_q, wdog_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_q, mem_req_d;
  logic [N_REQ-1:0]  ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  mem_cmd_t          req_cmd [N_REQ];
  logic              pick_valid, stay, grant;
  logic [IDX_W-1:0]  pick_idx, win;

  // Split the flat requester buses into per-requester commands.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_cmd[i].addr  = bus.addr[ADDR_W*i +: ADDR_W];
      req_cmd[i].wdata = bus.wdata[DATA_W*i +: DATA_W];
      req_cmd[i].wen   = bus.wen[i];
    end
  end

  mp64_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i     (bus.req),
    .last_i    (last_q),
    .valid_c_o (pick_valid),
    .idx_c_o   (pick_idx)
  );

  // burst_q == 0 means no current owner, so the first grant after reset goes round-robin.
  assign stay  = (burst_q != '0) && (burst_q < CNT_W'(MAX_BURST)) && bus.req[last_q];
  assign grant = stay || pick_valid;
  assign win   = stay ? last_q : pick_idx;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    g_d       = g_q;
    burst_d   = burst_q;
    wdog_d    = wdog_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    rdata_d   = rdata_q;
    ack_d     = '0;
    err_d     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          g_d       = win;
          burst_d   = stay ? burst_q + CNT_W'(1) : CNT_W'(1);
          cmd_d     = req_cmd[win];
          wdog_d    = '0;
          mem_req_d = 1'b1;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.mem_ack) begin
          rdata_d    = cmd_q.wen ? '0 : bus.mem_rdata;
          ack_d[g_q] = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ARB_DONE;
        end else if (wdog_q == CNT_W'(TIMEOUT)) begin
          rdata_d    = '0;
          ack_d[g_q] = 1'b1;
          err_d[g_q] = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ARB_DONE;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      ARB_DONE: begin
        last_d  = g_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      g_q       <= '0;
      burst_q   <= '0;
      wdog_q    <= '0;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      g_q       <= g_d;
      burst_q   <= burst_d;
      wdog_q    <= wdog_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.mem_wen   = cmd_q.wen;
  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mp64_dma_arb.sv
// Directed bench for mp64_dma_arb: two instances (burst limit 1 and 4, timeout 10).
module tb_mp64_dma_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  logic ack_auto1, ack_man1;

  always #5 clk = ~clk;

  mp64_dma_arb_if #(.N_REQ(4)) b1 ();
  mp64_dma_arb_if #(.N_REQ(4)) b4 ();

  // b1 memory: either answers in the first ISSUE cycle or under manual control.
  assign b1.mem_ack = ack_auto1 ? b1.mem_req : ack_man1;
  // b4 memory always answers immediately.
  assign b4.mem_ack = b4.mem_req;

  mp64_dma_arb #(.N_REQ(4), .MAX_BURST(1), .TIMEOUT(10)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );
  mp64_dma_arb #(.N_REQ(4), .MAX_BURST(4), .TIMEOUT(10)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (b4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ack_auto1 = 1'b0; ack_man1 = 1'b0;
    b1.req = '0; b1.addr = '0; b1.wdata = '0; b1.wen = '0; b1.mem_rdata = '0;
    b4.req = '0; b4.addr = '0; b4.wdata = '0; b4.wen = '0; b4.mem_rdata = '0;
    tick(); tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr, b1.mem_wdata, b1.mem_wen, b1.ack, b1.err, b1.rdata, b1.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_b1: mem_req=%b addr=%h ack=%b err=%b rdata=%h busy=%b, all must be 0",
               b1.mem_req, b1.mem_addr, b1.ack, b1.err, b1.rdata, b1.busy);
    end
    n_chk++;
    if ({b4.mem_req, b4.mem_addr, b4.mem_wdata, b4.mem_wen, b4.ack, b4.err, b4.rdata, b4.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_b4: mem_req=%b addr=%h ack=%b busy=%b, all must be 0",
               b4.mem_req, b4.mem_addr, b4.ack, b4.busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // All four requesting, limit 1: order 0,1,2,3,0, one ack every third cycle.
  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    for (int i = 0; i < 4; i++) b1.addr[64*i +: 64] = 64'h100 * (i + 1);
    ack_auto1 = 1'b1;
    b1.req = 4'b1111;
    for (int t = 1; t <= 15; t++) begin
      tick();
      exp_ack = (t % 3 == 2) ? 4'(1 << order[t/3]) : 4'b0000;
      n_chk++;
      if (b1.ack !== exp_ack) begin
        n_fail++;
        $display("FAIL fairness_t%0d: ack=%b expected %b", t, b1.ack, exp_ack);
      end
    end
    b1.req = '0;
    ack_auto1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single_read();
    b1.addr[64 +: 64] = 64'h1000;
    b1.wen = '0;
    b1.req = 4'b0010;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr, b1.mem_wen, b1.busy} !== {1'b1, 64'h1000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL read_issue: mem_req=%b addr=%h wen=%b busy=%b expected 1 1000 0 1",
               b1.mem_req, b1.mem_addr, b1.mem_wen, b1.busy);
    end
    tick(); tick(); tick();
    n_chk++;
    if ({b1.mem_req, b1.ack} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL read_hold: mem_req=%b ack=%b expected 1 0000", b1.mem_req, b1.ack);
    end
    ack_man1 = 1'b1;
    b1.mem_rdata = 8'hA5;
    tick();
    ack_man1 = 1'b0;
    b1.req = '0;
    n_chk++;
    if ({b1.ack, b1.err, b1.rdata, b1.mem_req} !== {4'b0010, 4'b0000, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL read_ack: ack=%b err=%b rdata=%h mem_req=%b expected 0010 0000 a5 0",
               b1.ack, b1.err, b1.rdata, b1.mem_req);
    end
    tick();
    n_chk++;
    if ({b1.ack, b1.busy} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL read_done: ack=%b busy=%b expected 0000 0", b1.ack, b1.busy);
    end
    tick();
  endtask

  // Requester 3 never answered: ack+err 11 cycles after mem_req, then requester 0 (a write).
  task automatic test_timeout();
    b1.addr[192 +: 64] = 64'h3000;
    b1.addr[0 +: 64]   = 64'h0500;
    b1.wdata[7:0]      = 8'h5A;
    b1.wen             = 4'b0001;
    b1.mem_rdata       = 8'h3C;
    b1.req             = 4'b1001;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr} !== {1'b1, 64'h3000}) begin
      n_fail++;
      $display("FAIL tmo_issue: mem_req=%b addr=%h expected 1 3000", b1.mem_req, b1.mem_addr);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_chk++;
      if ({b1.mem_req, b1.ack} !== {1'b1, 4'b0000}) begin
        n_fail++;
        $display("FAIL tmo_wait_%0d: mem_req=%b ack=%b expected 1 0000", t, b1.mem_req, b1.ack);
      end
    end
    tick();
    b1.req = 4'b0001;
    n_chk++;
    if ({b1.ack, b1.err, b1.mem_req, b1.rdata} !== {4'b1000, 4'b1000, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL tmo_abort: ack=%b err=%b mem_req=%b rdata=%h expected 1000 1000 0 00",
               b1.ack, b1.err, b1.mem_req, b1.rdata);
    end
    tick(); tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr, b1.mem_wen, b1.mem_wdata} !== {1'b1, 64'h0500, 1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL tmo_next: mem_req=%b addr=%h wen=%b wdata=%h expected 1 0500 1 5a",
               b1.mem_req, b1.mem_addr, b1.mem_wen, b1.mem_wdata);
    end
    ack_man1 = 1'b1;
    tick();
    ack_man1 = 1'b0;
    b1.req = '0;
    n_chk++;
    if ({b1.ack, b1.err, b1.rdata} !== {4'b0001, 4'b0000, 8'h00}) begin
      n_fail++;
      $display("FAIL tmo_write_ack: ack=%b err=%b rdata=%h expected 0001 0000 00",
               b1.ack, b1.err, b1.rdata);
    end
    tick(); tick();
    b1.wen = '0;
  endtask

  task automatic test_reset_mid_issue();
    b1.addr[0 +: 64]   = 64'h0600;
    b1.addr[192 +: 64] = 64'h3300;
    b1.req = 4'b1001;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr} !== {1'b1, 64'h3300}) begin
      n_fail++;
      $display("FAIL rst_pre: mem_req=%b addr=%h expected 1 3300", b1.mem_req, b1.mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({b1.mem_req, b1.ack, b1.busy} !== {1'b0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: mem_req=%b ack=%b busy=%b expected 0 0000 0",
               b1.mem_req, b1.ack, b1.busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr} !== {1'b1, 64'h0600}) begin
      n_fail++;
      $display("FAIL rst_first_grant: mem_req=%b addr=%h expected 1 0600", b1.mem_req, b1.mem_addr);
    end
    ack_man1 = 1'b1;
    tick();
    ack_man1 = 1'b0;
    b1.req = '0;
    n_chk++;
    if (b1.ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_first_ack: ack=%b expected 0001", b1.ack);
    end
    tick(); tick();
  endtask

  // Requester keeps req high through DONE with a new address; only IDLE may sample it.
  task automatic test_stale_req();
    b1.addr[128 +: 64] = 64'h2000;
    b1.req = 4'b0100;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr} !== {1'b1, 64'h2000}) begin
      n_fail++;
      $display("FAIL stale_first: mem_req=%b addr=%h expected 1 2000", b1.mem_req, b1.mem_addr);
    end
    ack_man1 = 1'b1;
    tick();
    ack_man1 = 1'b0;
    b1.addr[128 +: 64] = 64'h2001;
    tick();
    n_chk++;
    if ({b1.mem_req, b1.busy} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stale_ignored: mem_req=%b busy=%b expected 0 0", b1.mem_req, b1.busy);
    end
    tick();
    n_chk++;
    if ({b1.mem_req, b1.mem_addr} !== {1'b1, 64'h2001}) begin
      n_fail++;
      $display("FAIL stale_regrant: mem_req=%b addr=%h expected 1 2001", b1.mem_req, b1.mem_addr);
    end
    ack_man1 = 1'b1;
    tick();
    ack_man1 = 1'b0;
    b1.req = '0;
    tick(); tick();
  endtask

  // Limit 4: requester 0 held, requester 2 makes one request. Expect 0x4, 2, then 0 keeps
  // winning with its burst count restarting once the limit is hit alone.
  task automatic test_burst();
    int seq [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    logic [3:0] exp_ack;
    b4.req = 4'b0101;
    for (int t = 1; t <= 30; t++) begin
      tick();
      exp_ack = (t % 3 == 2) ? 4'(1 << seq[t/3]) : 4'b0000;
      n_chk++;
      if (b4.ack !== exp_ack) begin
        n_fail++;
        $display("FAIL burst_t%0d: ack=%b expected %b", t, b4.ack, exp_ack);
      end
      if (t == 14) b4.req[2] = 1'b0;
    end
    b4.req = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_timeout();
    test_reset_mid_issue();
    test_stale_req();
    test_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mp64_dma_arb.md
# mp64_dma_arb

Round-robin arbiter that shares the single byte-wide system-memory DMA port between up to N_REQ peripheral DMA engines (NIC RX/TX, storage, etc.). It sits between the peripheral DMA ports and the memory bus and registers all outgoing requests. It supports bounded per-requester bursts and enforces a watchdog timeout, so a stalled bus cannot hang every peripheral.

## Interface
- N_REQ, 4, number of requester ports (2..8)
- MAX_BURST, 16, max consecutive grants to one requester before forced rotation (1..255)
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (1..255)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held with addr/wdata/wen stable until its ack
- addr  in  64*N_REQ  byte address, requester i at [64*i+63:64*i]
- wdata  in  8*N_REQ  write data, requester i at [8*i+7:8*i]
- wen  in  N_REQ  1=write, 0=read
- rdata  out  8  read data for the acked requester, valid while its ack is high
- ack  out  N_REQ  one-cycle completion pulse, one-hot or zero
- err  out  N_REQ  one-cycle pulse coincident with ack when the access timed out
- mem_req  out  1  memory-bus request
- mem_addr  out  64  registered address
- mem_wdata  out  8  registered write data
- mem_wen  out  1  registered write enable
- mem_rdata  in  8  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: from req[] pick the winner.
  - If burst_cnt < MAX_BURST and req[last] is high: winner = last, burst_cnt+1.
  - Otherwise: round-robin search starting at last+1 mod N_REQ; burst_cnt = 1.
  - The chosen index g and addr/wdata/wen[g] are latched into mem_*. mem_req <= 1. Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: hold mem_* constant. wdog counts up from 0.
  - On mem_ack: rdata <= mem_rdata (reads; 0 for writes), ack[g] <= 1, mem_req <= 0. Go to DONE.
  - If wdog reaches TIMEOUT without mem_ack: mem_req <= 0, ack[g] <= 1, err[g] <= 1, rdata <= 0. Go to DONE.
- DONE: ack/err drop. req[] is ignored this cycle because the requester's req is stale. last <= g. Go to IDLE.
- If a requester drops req during ISSUE, the bus cycle still completes and ack[g] is still pulsed.
- When only one requester is active, it may be regranted indefinitely: the burst limit only matters when another req is pending. If the limit is reached with no other req pending, burst_cnt restarts at 1.
- Reset values: mem_req 0, mem_addr 0, mem_wdata 0, mem_wen 0, ack 0, err 0, rdata 0, busy 0, state IDLE, last = N_REQ-1 (so requester 0 wins first), burst_cnt 0, wdog 0.
- Asserting reset mid-transaction aborts immediately with no ack. The memory side must tolerate mem_req dropping.

## Timing
- Cycle 0: req[i] sampled high in IDLE.
- Cycle 1: mem_req high (ISSUE).
- mem_ack at cycle k ≥ 1 gives ack[i] at k+1.
- Minimum service is 3 cycles per beat (IDLE→ISSUE→DONE). Back-to-back peak throughput is 1 beat per 3 cycles.
- Timeout: ack/err rise TIMEOUT+1 cycles after mem_req rises. A mem_ack arriving in the same cycle the count hits TIMEOUT counts as success.
- No combinational path from any input to any output, except `busy` from the state register.
- Requester contract: after seeing ack, the requester may re-raise req the next cycle; it is sampled in IDLE.

## Structure
- mp64_pkg.vh: ARB_IDLE/ARB_ISSUE/ARB_DONE encodings (2-bit), and the default MAX_BURST/TIMEOUT constants.
- Sub-module mp64_rr_pick: combinational N_REQ-wide round-robin priority picker.
  - Inputs: req vector, last index.
  - Outputs: valid, index.
  - It is reused by the interrupt controller.
- Index width: $clog2(N_REQ). burst_cnt and wdog are 8 bits each.

## Test plan
- Single read: req[1], addr 0x1000; mem_ack with mem_rdata 0xA5 three cycles after mem_req -> mem_addr 0x1000, mem_wen 0, ack[1] plus rdata 0xA5 on the next cycle, err 0.
- Fairness: req[0..3] all held high, MAX_BURST=1, mem_ack immediate -> grant order 0,1,2,3,0; exactly one ack per 3 cycles.
- Burst limit: MAX_BURST=4, req[0] and req[2] held high -> four acks to 0, then one to 2, then four more to 0.
- Timeout: TIMEOUT=10, mem_ack never asserted -> ack[3] and err[3] pulse together 11 cycles after mem_req rises; mem_req falls; the next requester is served.
- Reset mid-ISSUE: assert rst_n low while mem_req is high -> mem_req, ack and busy go to 0 asynchronously; after release, req[0] is granted first.
- Stale req: the requester keeps req high for one cycle after its ack with new addr 0x2001 -> that cycle is ignored, and the next grant uses 0x2001, not the old address.
